// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control-unit bus between multicycle_control (master) and the datapath (slave)
// Datapath to control: instr, imem_ready, ir_op, zero.
// Control to datapath: imem_req, ir_write, pc_write, pc_src, ab_write, aluout_write, alu_src_a, alu_src_b,
//   alu_control, reg_dst, reg_write, halted, state, instr_count.
interface multicycle_control_if #(parameter int COUNT_WIDTH = 16);
  logic [15:0] instr;
  logic imem_ready;
  logic [3:0] ir_op;
  logic zero;
  logic imem_req;
  logic ir_write;
  logic pc_write;
  logic pc_src;
  logic ab_write;
  logic aluout_write;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_control;
  logic reg_dst;
  logic reg_write;
  logic halted;
  logic [2:0] state;
  logic [COUNT_WIDTH-1:0] instr_count;
  modport master (
    input instr, imem_ready, ir_op, zero,
    output imem_req, ir_write, pc_write, pc_src, ab_write, aluout_write, alu_src_a, alu_src_b,
           alu_control, reg_dst, reg_write, halted, state, instr_count
  );
  modport slave (
    output instr, imem_ready, ir_op, zero,
    input imem_req, ir_write, pc_write, pc_src, ab_write, aluout_write, alu_src_a, alu_src_b,
          alu_control, reg_dst, reg_write, halted, state, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle FSM sequencing a 16-bit datapath around one shared ALU
// Ports: clock, reset (sync, active-high); bus (master) carries the imem handshake, IR opcode, Zero flag,
//   datapath strobes, mux selects, ALU op, halted flag, debug state and retired-instruction count.
module multicycle_control #(
  parameter int COUNT_WIDTH = 16,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input logic clock,
  input logic reset,
  multicycle_control_if.master bus
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, WRITEBACK = 3'd3, HALT = 3'd4} state_t;
  // ALU op per opcode 0..7, opcode 0 in the low nibble; addi (7) is an add
  localparam logic [31:0] ALU_LUT = {4'b0010, 4'b0111, 4'b1101, 4'b1100, 4'b0001, 4'b0000, 4'b0110, 4'b0010};
  state_t state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic take;
  assign bus.state = state_q;
  assign bus.instr_count = count_q;
  // beq (1000) takes on zero=1, bne (1001) on zero=0
  assign take = bus.zero ^ bus.ir_op[0];
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    bus.imem_req = 1'b0;
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_src = 1'b0;
    bus.ab_write = 1'b0;
    bus.aluout_write = 1'b0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 2'b00;
    bus.alu_control = 4'b0000;
    bus.reg_dst = 1'b0;
    bus.reg_write = 1'b0;
    bus.halted = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          bus.imem_req = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.alu_control = 4'b0010;
          if (bus.imem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = bus.instr != HALT_WORD;
            state_d = bus.instr == HALT_WORD ? HALT : DECODE;
          end
        end
        DECODE: begin
          bus.ab_write = 1'b1;
          bus.aluout_write = 1'b1;
          bus.alu_src_b = 2'b11;
          bus.alu_control = 4'b0010;
          state_d = EXECUTE;
        end
        EXECUTE: begin
          if (!bus.ir_op[3]) begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = bus.ir_op == 4'b0111 ? 2'b10 : 2'b00;
            bus.alu_control = ALU_LUT[{bus.ir_op[2:0], 2'b00} +: 4];
            bus.aluout_write = 1'b1;
            state_d = WRITEBACK;
          end else begin
            if (bus.ir_op[3:1] == 3'b100) begin
              bus.alu_src_a = 1'b1;
              bus.alu_control = 4'b0110;
              bus.pc_write = take;
              bus.pc_src = take;
            end
            count_d = count_q + COUNT_WIDTH'(1);
            state_d = FETCH;
          end
        end
        WRITEBACK: begin
          bus.reg_write = 1'b1;
          bus.reg_dst = bus.ir_op != 4'b0111;
          count_d = count_q + COUNT_WIDTH'(1);
          state_d = FETCH;
        end
        HALT: bus.halted = 1'b1;
        default: state_d = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized self-checking bench with an instruction-level reference model
module tb_multicycle_control;
  localparam logic [15:0] HALT = 16'hFFFF;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [15:0] ir = '0;
  int chk = 0;
  int fails = 0;
  int count_m = 0;
  logic [3:0] alu_tab [10] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b1101, 4'b0111, 4'b0010, 4'b0110, 4'b0110};
  logic [6:0] strb;
  multicycle_control_if #(.COUNT_WIDTH(16)) bus ();
  multicycle_control #(.COUNT_WIDTH(16), .HALT_WORD(16'hFFFF)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) if (bus.ir_write) ir <= bus.instr;
  assign bus.ir_op = ir[15:12];
  assign strb = {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.ab_write, bus.aluout_write, bus.reg_write};

  task automatic exec_instr(input logic [15:0] w, input int waits, input logic z);
    logic [3:0] op;
    logic hlt, alu, br, take;
    logic [6:0] ex_strb;
    op = w[15:12];
    hlt = w == HALT;
    alu = op < 4'd8;
    br = op == 4'd8 || op == 4'd9;
    take = br && ((op == 4'd8) == z);
    bus.zero = z;
    for (int i = 0; i < waits; i++) begin
      bus.imem_ready = 1'b0;
      bus.instr = 16'($urandom);
      @(negedge clock);
      chk++;
      if (strb !== 7'b1000000 || bus.state !== 3'd0) begin
        fails++;
        $display("FAIL fetch_wait %h: strobes=%b state=%0d, want strobes=1000000 state=0", w, strb, bus.state);
      end
      @(posedge clock); #1;
    end
    bus.imem_ready = 1'b1;
    bus.instr = w;
    @(negedge clock);
    chk++;
    if (strb !== {2'b11, !hlt, 4'b0000} || bus.state !== 3'd0 || bus.alu_src_a !== 1'b0 || bus.alu_src_b !== 2'b01 || bus.alu_control !== 4'b0010) begin
      fails++;
      $display("FAIL fetch %h: strobes=%b state=%0d a=%b b=%b alu=%b, want strobes=%b state=0 a=0 b=01 alu=0010",
               w, strb, bus.state, bus.alu_src_a, bus.alu_src_b, bus.alu_control, {2'b11, !hlt, 4'b0000});
    end
    @(posedge clock); #1;
    bus.imem_ready = 1'($urandom);
    bus.instr = 16'($urandom);
    if (hlt) return;
    @(negedge clock);
    chk++;
    if (strb !== 7'b0000110 || bus.state !== 3'd1 || bus.alu_src_a !== 1'b0 || bus.alu_src_b !== 2'b11 || bus.alu_control !== 4'b0010) begin
      fails++;
      $display("FAIL decode %h: strobes=%b state=%0d a=%b b=%b alu=%b, want strobes=0000110 state=1 a=0 b=11 alu=0010",
               w, strb, bus.state, bus.alu_src_a, bus.alu_src_b, bus.alu_control);
    end
    @(posedge clock); #1;
    bus.imem_ready = 1'($urandom);
    @(negedge clock);
    ex_strb = alu ? 7'b0000010 : {2'b00, take, take, 3'b000};
    chk++;
    if (strb !== ex_strb || bus.state !== 3'd2) begin
      fails++;
      $display("FAIL execute_strobes %h z=%b: strobes=%b state=%0d, want strobes=%b state=2", w, z, strb, bus.state, ex_strb);
    end
    if (alu || br) begin
      chk++;
      if (bus.alu_src_a !== 1'b1 || bus.alu_control !== alu_tab[op] || bus.alu_src_b !== (op == 4'd7 ? 2'b10 : 2'b00)) begin
        fails++;
        $display("FAIL execute_alu %h: a=%b b=%b alu=%b, want a=1 b=%b alu=%b",
                 w, bus.alu_src_a, bus.alu_src_b, bus.alu_control, (op == 4'd7 ? 2'b10 : 2'b00), alu_tab[op]);
      end
    end
    if (alu) begin
      @(posedge clock); #1;
      @(negedge clock);
      chk++;
      if (strb !== 7'b0000001 || bus.state !== 3'd3 || bus.reg_dst !== (op != 4'd7)) begin
        fails++;
        $display("FAIL writeback %h: strobes=%b state=%0d reg_dst=%b, want strobes=0000001 state=3 reg_dst=%b",
                 w, strb, bus.state, bus.reg_dst, op != 4'd7);
      end
    end
    count_m++;
    @(posedge clock); #1;
    chk++;
    if (bus.state !== 3'd0 || bus.instr_count !== 16'(count_m)) begin
      fails++;
      $display("FAIL retire %h: state=%0d count=%0d, want state=0 count=%0d", w, bus.state, bus.instr_count, count_m);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.imem_ready = 1'b1;
    bus.instr = HALT;
    @(posedge clock); #1;
    @(negedge clock);
    chk++;
    if (strb !== 7'b0 || bus.halted !== 1'b0 || bus.alu_src_a !== 1'b0 || bus.alu_src_b !== 2'b00 || bus.alu_control !== 4'b0 || bus.reg_dst !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: strobes=%b halted=%b a=%b b=%b alu=%b dst=%b, want all 0",
               strb, bus.halted, bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.reg_dst);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    count_m = 0;
    chk++;
    if (bus.state !== 3'd0 || bus.instr_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: state=%0d count=%0d, want 0 0", bus.state, bus.instr_count);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_addi();
    exec_instr(16'b0111_00_01_00001111, 0, 1'b0);
  endtask

  task automatic test_wait();
    exec_instr(16'h1234, 3, 1'b1);
  endtask

  task automatic test_branch();
    exec_instr(16'h8000, 0, 1'b1);
    exec_instr(16'h8000, 0, 1'b0);
    exec_instr(16'h9000, 0, 1'b1);
    exec_instr(16'h9000, 1, 1'b0);
  endtask

  task automatic test_halt();
    do_reset();
    exec_instr(16'h1000, 0, 1'b0);
    exec_instr(16'h6000, 0, 1'b0);
    exec_instr(HALT, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      bus.imem_ready = 1'($urandom);
      bus.instr = 16'($urandom);
      @(negedge clock);
      chk++;
      if (strb !== 7'b0 || bus.halted !== 1'b1 || bus.state !== 3'd4 || bus.instr_count !== 16'd2) begin
        fails++;
        $display("FAIL halt_hold: strobes=%b halted=%b state=%0d count=%0d, want 0 1 4 2", strb, bus.halted, bus.state, bus.instr_count);
      end
      @(posedge clock); #1;
    end
    do_reset();
    bus.imem_ready = 1'b0;
    @(negedge clock);
    chk++;
    if (bus.halted !== 1'b0 || bus.imem_req !== 1'b1) begin
      fails++;
      $display("FAIL halt_resume: halted=%b imem_req=%b, want 0 1", bus.halted, bus.imem_req);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    bus.imem_ready = 1'b1;
    bus.instr = 16'h0123;
    @(posedge clock); #1;
    bus.imem_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk++;
    if (bus.state !== 3'd2 || bus.aluout_write !== 1'b0 || bus.reg_write !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: state=%0d aluout_write=%b reg_write=%b, want 2 0 0", bus.state, bus.aluout_write, bus.reg_write);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    count_m = 0;
    chk++;
    if (bus.state !== 3'd0 || bus.instr_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid_after: state=%0d count=%0d, want 0 0", bus.state, bus.instr_count);
    end
  endtask

  task automatic test_nop();
    exec_instr(16'hF000, 0, 1'b0);
    exec_instr(16'hA5A5, 2, 1'b1);
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 40; i++) begin
      w = 16'($urandom);
      if (w == HALT) w = 16'h0000;
      exec_instr(w, int'($urandom_range(0, 2)), 1'($urandom));
    end
  endtask

  initial begin
    bus.instr = '0;
    bus.imem_ready = 1'b0;
    bus.zero = 1'b0;
    test_reset();
    test_addi();
    test_wait();
    test_branch();
    test_nop();
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences the 16-bit datapath in multicycle form, time-sharing one ALU between PC increment, branch-target calculation and instruction execution.
- Replaces the single-cycle control unit and the dedicated fetch adder.
- Drives the strobes for IR, PC, the A/B operand latches, the ALUOut latch and the register file.
- Handles an instruction-memory ready handshake, BEQ/BNE, halt detection and a retired-instruction counter.

Parameters:
- COUNT_WIDTH, 16, width of instr_count.
- HALT_WORD, 16'hFFFF, fetched word that halts the machine.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  16  instruction memory read data (valid when imem_ready=1).
- imem_ready  in  1  memory has valid data for the current request.
- ir_op  in  4  IR[15:12] from the latched IR.
- zero  in  1  ALU Zero flag.
- imem_req  out  1  fetch request.
- ir_write  out  1  latch instr into IR.
- pc_write  out  1  load PC.
- pc_src  out  1  0 = live ALU result, 1 = ALUOut latch (branch target).
- ab_write  out  1  latch RD1/RD2 into A/B.
- aluout_write  out  1  latch the ALU result.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B; 01 = constant 2; 10 = sign-extended IR[7:0]; 11 = sign-extended IR[5:0]<<1.
- alu_control  out  4  ALU operation code, with the same encoding the ALU uses.
- reg_dst  out  1  1 = IR[7:6], 0 = IR[9:8].
- reg_write  out  1  register file write enable.
- halted  out  1  machine is halted.
- state  out  3  current state, for debug.
- instr_count  out  COUNT_WIDTH  count of retired instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, HALT=4.
- Reset:
  - Next edge sets state=FETCH and instr_count=0.
  - While reset=1, every strobe output is 0: imem_req, ir_write, pc_write, ab_write, aluout_write, reg_write.
  - While reset=1, halted=0, and the mux selects and alu_control are 0.
  - Reset in any state, including HALT, aborts the current instruction with no write.
- Strobes default to 0 in every state unless listed below.
- FETCH:
  - imem_req=1, alu_src_a=0, alu_src_b=01, alu_control=0010.
  - imem_ready=0: hold state, no strobes.
  - imem_ready=1 and instr!=HALT_WORD: ir_write=1, pc_write=1, pc_src=0 (PC<=PC+2), next state DECODE.
  - imem_ready=1 and instr==HALT_WORD: ir_write=1, no pc_write, next state HALT.
  - imem_ready while not in FETCH is ignored.
- DECODE:
  - ab_write=1, aluout_write=1, alu_src_a=0, alu_src_b=11, alu_control=0010 (branch target).
  - Next state EXECUTE.
- EXECUTE:
  - Op 0000–0110 (add, sub, and, or, nor, nand, slt): alu_src_a=1, alu_src_b=00, alu_control = 0010, 0110, 0000, 0001, 1100, 1101, 0111 respectively. aluout_write=1. Next state WRITEBACK.
  - Op 0111 (addi): alu_src_a=1, alu_src_b=10, alu_control=0010, aluout_write=1. Next state WRITEBACK.
  - Op 1000 (beq) and 1001 (bne): alu_src_a=1, alu_src_b=00, alu_control=0110.
    - pc_write=1 and pc_src=1 iff zero=1 for beq, or zero=0 for bne.
    - instr_count increments. Next state FETCH.
  - Any other op: no strobes (NOP), instr_count increments, next state FETCH.
- WRITEBACK:
  - reg_write=1.
  - reg_dst=1 for ops 0000–0110, 0 for 0111.
  - instr_count increments. Next state FETCH.
  - Writes to R0 are suppressed by the register file, not here.
- HALT:
  - halted=1, no strobes, stays until reset.
  - The halt word is not counted in instr_count.
- Latency with imem_ready=1 in the first FETCH cycle: ALU ops 4 cycles; branch and NOP 3 cycles; each wait cycle adds 1.
- instr_count wraps modulo 2^COUNT_WIDTH.
- Outputs depend on state plus imem_ready and instr (FETCH) and ir_op and zero (EXECUTE/WRITEBACK). No combinational path from outputs back to inputs.

Test Plan:
- Reset, then imem_ready=1 with instr=0111_00_01_00001111 (addi) → states 0,1,2,3,0. Cycle 1: ir_write=pc_write=1, alu_src_b=01. Cycle 3: alu_src_b=10, alu_control=0010. Cycle 4: reg_write=1, reg_dst=0. instr_count=1.
- imem_ready held 0 for 3 cycles, then 1 → imem_req=1 for 4 cycles; ir_write pulses only in the 4th; no pc_write before it.
- beq (op 1000) with zero=1 → EXECUTE asserts pc_write=1, pc_src=1, alu_control=0110. Same with zero=0 → pc_write=0. bne inverts both. Branch returns to FETCH after 3 cycles.
- Sequence of op 0001, op 0110, then instr=16'hFFFF → alu_control 0110 then 0111. On FFFF: ir_write=1, pc_write=0, state=4, halted=1 held for 10+ cycles with all strobes 0, instr_count=2.
- reset=1 during EXECUTE of add → no aluout_write or reg_write that cycle; state=0 and instr_count=0 next edge. Reset during HALT → halted=0 and fetch resumes.
- Op 1111 with instr!=FFFF (e.g. 16'hF000) → NOP: DECODE, EXECUTE, then FETCH; reg_write never asserted; instr_count increments.
